tick_pwm_gen: RTL and testbench

//  Tick-driven PWM generator; sits downstream of the modulo prescaler counter and consumes its

---
 rtl/tick_pwm_pkg.sv | 11 +
 rtl/pwm_cfg_shadow.sv | 75 +++++++
 rtl/tick_pwm_gen.sv | 88 ++++++++
 tb/tb_tick_pwm_gen.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/tick_pwm_pkg.sv
// Shared constants for the tick-driven PWM generator.
// State encodings and default counter width.
package tick_pwm_pkg;

  localparam int PW_CNT_DEF = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

endpackage

// File: rtl/pwm_cfg_shadow.sv
// Config handshake with one-deep shadow register.
// Loads active values directly when idle, else on apply (period wrap).
module pwm_cfg_shadow
  import tick_pwm_pkg::*;
#(
  parameter int PW_CNT = PW_CNT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [PW_CNT-1:0] i_cfg_period,
  input  logic [PW_CNT-1:0] i_cfg_duty,
  input  logic              i_load_direct,
  input  logic              i_apply,
  output logic [PW_CNT-1:0] o_period_act,
  output logic [PW_CNT-1:0] o_duty_act,
  output logic              o_pend_zero
);

  logic              pend_q, pend_d;
  logic [PW_CNT-1:0] per_act_q, per_act_d;
  logic [PW_CNT-1:0] duty_act_q, duty_act_d;
  logic [PW_CNT-1:0] per_sh_q, per_sh_d;
  logic [PW_CNT-1:0] duty_sh_q, duty_sh_d;
  logic              xfer;

  assign o_cfg_ready  = !pend_q;
  assign xfer         = i_cfg_valid && !pend_q;
  assign o_period_act = per_act_q;
  assign o_duty_act   = duty_act_q;
  assign o_pend_zero  = pend_q && (per_sh_q == '0);

  // Next-state: apply pending shadow at wrap, capture on transfer.
  always_comb begin
    pend_d     = pend_q;
    per_act_d  = per_act_q;
    duty_act_d = duty_act_q;
    per_sh_d   = per_sh_q;
    duty_sh_d  = duty_sh_q;
    if (i_apply && pend_q) begin
      per_act_d  = per_sh_q;
      duty_act_d = duty_sh_q;
      pend_d     = 1'b0;
    end
    if (xfer) begin
      if (i_load_direct) begin
        per_act_d  = i_cfg_period;
        duty_act_d = i_cfg_duty;
      end else begin
        per_sh_d  = i_cfg_period;
        duty_sh_d = i_cfg_duty;
        pend_d    = 1'b1;
      end
    end
  end

  // Config registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= 1'b0;
      per_act_q  <= '0;
      duty_act_q <= '0;
      per_sh_q   <= '0;
      duty_sh_q  <= '0;
    end else begin
      pend_q     <= pend_d;
      per_act_q  <= per_act_d;
      duty_act_q <= duty_act_d;
      per_sh_q   <= per_sh_d;
      duty_sh_q  <= duty_sh_d;
    end
  end

endmodule

// File: rtl/tick_pwm_gen.sv
// Tick-driven PWM generator with glitch-free config updates.
// Holds run/stop FSM, tick counter, duty compare and end pulse.
module tick_pwm_gen
  import tick_pwm_pkg::*;
#(
  parameter int PW_CNT = PW_CNT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_tick,
  input  logic              i_en,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [PW_CNT-1:0] i_cfg_period,
  input  logic [PW_CNT-1:0] i_cfg_duty,
  output logic              o_pwm,
  output logic              o_period_end,
  output logic              o_busy
);

  logic [1:0]        state_q, state_d;
  logic [PW_CNT-1:0] cnt_q, cnt_d;
  logic              pe_q, pe_d;
  logic [PW_CNT-1:0] period_act;
  logic [PW_CNT-1:0] duty_act;
  logic              pend_zero;
  logic              busy;
  logic              wrap;

  assign busy = (state_q != ST_IDLE);
  assign wrap = busy && i_tick &&
                (cnt_q == period_act - PW_CNT'(1));

  pwm_cfg_shadow #(
    .PW_CNT(PW_CNT)
  ) u_cfg (
    .clk          (clk),
    .rst          (rst),
    .i_cfg_valid  (i_cfg_valid),
    .o_cfg_ready  (o_cfg_ready),
    .i_cfg_period (i_cfg_period),
    .i_cfg_duty   (i_cfg_duty),
    .i_load_direct(!busy),
    .i_apply      (wrap),
    .o_period_act (period_act),
    .o_duty_act   (duty_act),
    .o_pend_zero  (pend_zero)
  );

  // FSM and counter next-state; wrap may force return to idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (i_en && period_act != '0)
          state_d = ST_RUN;
      end
      ST_RUN:  if (!i_en) state_d = ST_STOP;
      ST_STOP: if (i_en)  state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
    if (busy && i_tick)
      cnt_d = wrap ? '0 : cnt_q + PW_CNT'(1);
    if (wrap && (state_q == ST_STOP || pend_zero))
      state_d = ST_IDLE;
    pe_d = wrap;
  end

  // State, counter and end-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pe_q    <= pe_d;
    end
  end

  assign o_pwm        = busy && (cnt_q < duty_act);
  assign o_period_end = pe_q;
  assign o_busy       = busy;

endmodule

// File: tb/tb_tick_pwm_gen.sv
// Directed bench for tick_pwm_gen.
// Expected output bit patterns are hand-computed per step.
module tb_tick_pwm_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_tick;
  logic       i_en;
  logic       i_cfg_valid;
  logic       o_cfg_ready;
  logic [7:0] i_cfg_period;
  logic [7:0] i_cfg_duty;
  logic       o_pwm;
  logic       o_period_end;
  logic       o_busy;

  int checks   = 0;
  int failures = 0;

  tick_pwm_gen #(.PW_CNT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_tick      (i_tick),
    .i_en        (i_en),
    .i_cfg_valid (i_cfg_valid),
    .o_cfg_ready (o_cfg_ready),
    .i_cfg_period(i_cfg_period),
    .i_cfg_duty  (i_cfg_duty),
    .o_pwm       (o_pwm),
    .o_period_end(o_period_end),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  task automatic run(input string tag, input int n,
                     input logic [31:0] ep, input logic [31:0] epe,
                     input logic [31:0] erd, input logic [31:0] ebz);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks += 4;
      assert (o_pwm === ep[i]) else begin
        failures++;
        $error("FAIL %s[%0d] pwm got %b exp %b", tag, i, o_pwm, ep[i]);
      end
      assert (o_period_end === epe[i]) else begin
        failures++;
        $error("FAIL %s[%0d] pend got %b exp %b", tag, i, o_period_end, epe[i]);
      end
      assert (o_cfg_ready === erd[i]) else begin
        failures++;
        $error("FAIL %s[%0d] ready got %b exp %b", tag, i, o_cfg_ready, erd[i]);
      end
      assert (o_busy === ebz[i]) else begin
        failures++;
        $error("FAIL %s[%0d] busy got %b exp %b", tag, i, o_busy, ebz[i]);
      end
    end
  endtask

  task automatic offer(input logic [7:0] p, input logic [7:0] d);
    i_cfg_valid  = 1'b1;
    i_cfg_period = p;
    i_cfg_duty   = d;
  endtask

  initial begin
    rst = 1'b1; i_tick = 1'b1; i_en = 1'b0;
    i_cfg_valid = 1'b0; i_cfg_period = '0; i_cfg_duty = '0;
    run("reset", 1, 0, 0, 1, 0);

    // 1: period 4 duty 1
    rst = 1'b0; i_en = 1'b1;
    offer(8'd4, 8'd1);
    run("cfg_idle", 1, 0, 0, 1, 0);
    i_cfg_valid = 1'b0;
    run("p4d1", 9, 9'h111, 9'h110, 9'h1FF, 9'h1FF);

    // 2: mid-period reconfig to 5/3, stalled second offer
    run("p4d1_c1", 1, 0, 0, 1, 1);
    offer(8'd5, 8'd3);
    run("offer53", 1, 0, 0, 0, 1);
    offer(8'd2, 8'd2);
    run("stall", 1, 0, 0, 0, 1);
    i_cfg_valid = 1'b0;
    run("p5d3", 6, 6'b100111, 6'b100001, 6'h3F, 6'h3F);

    // 3: duty 0, duty above period, period 1
    offer(8'd4, 8'd0);
    run("off_d0", 1, 1, 0, 0, 1);
    i_cfg_valid = 1'b0;
    run("d0", 8, 8'h01, 8'h88, 8'hF8, 8'hFF);
    offer(8'd4, 8'd9);
    run("off_d9", 1, 0, 0, 0, 1);
    i_cfg_valid = 1'b0;
    run("d9", 7, 7'h7C, 7'h44, 7'h7C, 7'h7F);
    offer(8'd1, 8'd1);
    run("off_p1", 1, 1, 0, 0, 1);
    i_cfg_valid = 1'b0;
    run("p1", 6, 6'h3F, 6'h3C, 6'h3C, 6'h3F);

    // offer on a wrap cycle applies at the following wrap
    offer(8'd4, 8'd1);
    run("off_wrap", 1, 1, 1, 0, 1);
    i_cfg_valid = 1'b0;
    run("p4_back", 2, 2'b01, 2'b01, 2'b11, 2'b11);

    // 4: stop at cnt 1, finish period, idle
    i_en = 1'b0;
    run("stop", 4, 0, 4'b0100, 4'hF, 4'b0011);
    i_en = 1'b1;
    run("restart", 2, 2'b01, 0, 2'b11, 2'b11);
    i_en = 1'b0;
    run("stop2", 1, 0, 0, 1, 1);
    i_en = 1'b1;
    run("resume", 6, 6'b100010, 6'b100010, 6'h3F, 6'h3F);

    // 5: pending period 0 ends the run; period 0 stays idle
    offer(8'd0, 8'd0);
    run("off_p0", 1, 0, 0, 0, 1);
    i_cfg_valid = 1'b0;
    run("p0", 5, 0, 5'b00100, 5'b11100, 5'b00011);
    offer(8'd0, 8'd5);
    run("idle_p0", 2, 0, 0, 2'b11, 0);
    i_cfg_valid = 1'b0;

    // 6: reset on a would-be wrap cycle
    offer(8'd4, 8'd3);
    run("ld_p4d3", 1, 0, 0, 1, 0);
    i_cfg_valid = 1'b0;
    run("p4d3", 4, 4'b0111, 0, 4'hF, 4'hF);
    rst = 1'b1;
    run("rst_mid", 1, 0, 0, 1, 0);
    rst = 1'b0;
    run("after_rst", 2, 0, 0, 2'b11, 0);

    // sparse ticks, one per 7 cycles
    i_tick = 1'b0;
    offer(8'd4, 8'd2);
    run("ld_sparse", 1, 0, 0, 1, 0);
    i_cfg_valid = 1'b0;
    run("run_sparse", 1, 1, 0, 1, 1);
    run("sp1", 6, 6'h3F, 0, 6'h3F, 6'h3F);
    i_tick = 1'b1;
    run("sp1t", 1, 1, 0, 1, 1);
    i_tick = 1'b0;
    run("sp2", 6, 6'h3F, 0, 6'h3F, 6'h3F);
    i_tick = 1'b1;
    run("sp2t", 1, 0, 0, 1, 1);
    i_tick = 1'b0;
    run("sp3", 6, 0, 0, 6'h3F, 6'h3F);
    i_tick = 1'b1;
    run("sp3t", 1, 0, 0, 1, 1);
    i_tick = 1'b0;
    run("sp4", 6, 0, 0, 6'h3F, 6'h3F);
    i_tick = 1'b1;
    run("sp4t", 1, 1, 1, 1, 1);
    i_tick = 1'b0;
    run("sp_end", 1, 1, 0, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
